// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, inst, next_pc} with redirect flush.
// Optional stall/flush counters when FETCH_QUEUE_STATS_EN is defined.
module fetch_queue #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_next_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_next_pc,
  output logic [PTR_W:0]   count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count
`endif
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_pc      [DEPTH];
  logic [31:0]      r_inst    [DEPTH];
  logic [31:0]      r_next_pc [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  // in_ready looks only at occupancy so out_ready never reaches it combinationally.
  assign in_ready    = (r_count != FULL);
  assign out_valid   = (r_count != '0);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign count       = r_count;
  assign out_pc      = r_pc[r_rd_ptr];
  assign out_inst    = r_inst[r_rd_ptr];
  assign out_next_pc = r_next_pc[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]      <= '0;
        r_inst[i]    <= '0;
        r_next_pc[i] <= '0;
      end
    end else if (flush) begin
      // Array contents are left in place; only the bookkeeping is discarded.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc[r_wr_ptr]      <= in_pc;
        r_inst[r_wr_ptr]    <= in_inst;
        r_next_pc[r_wr_ptr] <= in_next_pc;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (in_valid && !in_ready) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (flush && (r_count != '0)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand sequences and a queue-model random run.
module tb_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [31:0] in_next_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_next_pc;
  logic [1:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .in_next_pc  (in_next_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_next_pc (out_next_pc),
    .count       (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] pc;
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_cnt;
    logic        chk_dat;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [10];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
  } trip_t;

  trip_t mq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl, input logic [31:0] pc,
                              input logic e_ov, input logic e_ir, input logic [1:0] e_cnt,
                              input logic chk_dat, input logic [31:0] e_pc);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.chk_dat = chk_dat; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h20080005 : (32'hC0DE0000 ^ pc);
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [31:0] pc);
    in_valid   = iv;
    out_ready  = ordy;
    flush      = fl;
    in_pc      = pc;
    in_inst    = inst_of(pc);
    in_next_pc = pc + 32'd4;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    //                 iv   ordy fl   pc            ov   ir   cnt  dat  head pc
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 2'd1, 1'b1, 32'h00);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, 32'h04, 1'b1, 1'b0, 2'd2, 1'b1, 32'h00);
    vecs[2] = mk(1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 1'b0, 2'd2, 1'b1, 32'h00);
    vecs[3] = mk(1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 2'd1, 1'b1, 32'h04);
    vecs[4] = mk(1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 2'd0, 1'b0, 32'h00);
    vecs[5] = mk(1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 2'd1, 1'b1, 32'h10);
    vecs[6] = mk(1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 1'b0, 2'd2, 1'b1, 32'h10);
    vecs[7] = mk(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 2'd0, 1'b0, 32'h00);
    vecs[8] = mk(1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 2'd1, 1'b1, 32'h40);
    vecs[9] = mk(1'b1, 1'b1, 1'b0, 32'h44, 1'b1, 1'b1, 2'd1, 1'b1, 32'h44);

    // Reset state
    do_reset();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_count", {30'b0, count}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_next_pc", out_next_pc, 32'd0);

    // Directed table: first push, full/blocked push, pop, flush with push, push+pop
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc);
      cyc();
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
      chk($sformatf("vec%0d_count", i), {30'b0, count}, {30'b0, vecs[i].e_cnt});
      if (vecs[i].chk_dat) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_out_inst", i), out_inst, inst_of(vecs[i].e_pc));
        chk($sformatf("vec%0d_out_next_pc", i), out_next_pc, vecs[i].e_pc + 32'd4);
      end
    end

    // Streaming: push and pop every cycle, head trails by one cycle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i * 4));
      cyc();
      chk($sformatf("stream%0d_count", i), {30'b0, count}, 32'd1);
      chk($sformatf("stream%0d_out_pc", i), out_pc, 32'(i * 4));
    end

    // Reset while full with a push pending
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h100); cyc();
    drive(1'b1, 1'b0, 1'b0, 32'h104); cyc();
    chk("prefull_count", {30'b0, count}, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'h108);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_count", {30'b0, count}, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_inst", out_inst, 32'd0);

`ifdef FETCH_QUEUE_STATS_EN
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h10); cyc();
    drive(1'b1, 1'b0, 1'b0, 32'h14); cyc();
    chk("stats_nostall", stall_cycles, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h18);
    repeat (5) cyc();
    drive(1'b0, 1'b0, 1'b1, 32'h0); cyc();
    chk("stats_stall", stall_cycles, 32'd5);
    chk("stats_flush", {16'b0, flush_count}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 32'h0); cyc();
    chk("stats_flush_empty", {16'b0, flush_count}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("stats_rst_stall", stall_cycles, 32'd0);
    chk("stats_rst_flush", {16'b0, flush_count}, 32'd0);
`endif

    // Randomised run against a queue model
    do_reset();
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      logic        r_iv, r_or, r_fl, r_rst, m_push, m_pop;
      trip_t       t;
      r_iv  = ($urandom_range(0, 3) != 0);
      r_or  = ($urandom_range(0, 2) != 0);
      r_fl  = ($urandom_range(0, 14) == 0);
      r_rst = ($urandom_range(0, 99) == 0);
      t.pc   = $urandom;
      t.inst = $urandom;
      t.npc  = $urandom;
      in_valid   = r_iv;
      out_ready  = r_or;
      flush      = r_fl;
      rst        = r_rst;
      in_pc      = t.pc;
      in_inst    = t.inst;
      in_next_pc = t.npc;
      m_push = r_iv && (mq.size() < DEPTH);
      m_pop  = r_or && (mq.size() > 0);
      cyc();
      if (r_rst || r_fl) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(t);
      end
      rst = 1'b0;
      chk("rand_count", {30'b0, count}, 32'(mq.size()));
      chk("rand_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
      chk("rand_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < DEPTH});
      if (mq.size() > 0) begin
        chk("rand_out_pc", out_pc, mq[0].pc);
        chk("rand_out_inst", out_inst, mq[0].inst);
        chk("rand_out_next_pc", out_next_pc, mq[0].npc);
      end
      if (r_rst) chk("rand_rst_out_inst", out_inst, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
